// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with registered reads and same-cycle write bypass
module regfile_2r1w #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] raddr_a,
   input  logic [DEPTH_LOG2-1:0] raddr_b,
   output logic [WIDTH-1:0]      rdata_a,
   output logic [WIDTH-1:0]      rdata_b,
   output logic                  bypass_a,
   output logic                  bypass_b
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
   logic             bypass_a_q, bypass_a_d;
   logic             bypass_b_q, bypass_b_d;
   logic             wr_live;

   // Write strobe is qualified by we first, so an unknown waddr while idle cannot land anywhere.
   assign wr_live = we && (waddr != '0);

   always_ff @(posedge clk) begin
      if (areset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_live) begin
         regs_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a_d  = regs_q[raddr_a];
      bypass_a_d = 1'b0;
      if (raddr_a == '0) begin
         rdata_a_d = '0;
      end else if (we && (waddr == raddr_a)) begin
         rdata_a_d  = wdata;
         bypass_a_d = 1'b1;
      end
   end

   always_comb begin
      rdata_b_d  = regs_q[raddr_b];
      bypass_b_d = 1'b0;
      if (raddr_b == '0) begin
         rdata_b_d = '0;
      end else if (we && (waddr == raddr_b)) begin
         rdata_b_d  = wdata;
         bypass_b_d = 1'b1;
      end
   end

   // rd_en low is an ID-stage stall: both ports hold their last capture.
   always_ff @(posedge clk) begin
      if (areset) begin
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
         bypass_a_q <= 1'b0;
         bypass_b_q <= 1'b0;
      end else if (rd_en) begin
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
         bypass_a_q <= bypass_a_d;
         bypass_b_q <= bypass_b_d;
      end
   end

   assign rdata_a  = rdata_a_q;
   assign rdata_b  = rdata_b_q;
   assign bypass_a = bypass_a_q;
   assign bypass_b = bypass_b_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - randomized and directed checks of regfile_2r1w against a behavioural model
module tb_regfile_2r1w;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        rd_en = 1'b0;
   logic [4:0]  raddr_a = '0;
   logic [4:0]  raddr_b = '0;
   logic [31:0] rdata_a, rdata_b;
   logic        bypass_a, bypass_b;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic [31:0] mem [32];
   logic [31:0] m_ra = '0, m_rb = '0;
   logic        m_ba = 1'b0, m_bb = 1'b0;

   regfile_2r1w #(.WIDTH(32), .DEPTH_LOG2(5)) dut (
      .clk(clk), .areset(areset), .we(we), .waddr(waddr), .wdata(wdata),
      .rd_en(rd_en), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .bypass_a(bypass_a), .bypass_b(bypass_b)
   );

   always #5 clk = ~clk;

   // What a read of register x returns at this edge: {bypass, data}.
   function automatic logic [32:0] value_of(input logic [4:0] x);
      if (x == 5'd0) return {1'b0, 32'd0};
      if (we && waddr == x) return {1'b1, wdata};
      return {1'b0, mem[x]};
   endfunction

   always @(posedge clk) begin
      logic [32:0] va, vb;
      if (areset) begin
         foreach (mem[i]) mem[i] = 32'd0;
         m_ra = '0; m_rb = '0; m_ba = 1'b0; m_bb = 1'b0;
      end else begin
         va = value_of(raddr_a);
         vb = value_of(raddr_b);
         if (rd_en) begin
            {m_ba, m_ra} = va;
            {m_bb, m_rb} = vb;
         end
         if (we && waddr != 5'd0) mem[waddr] = wdata;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (rdata_a !== m_ra || rdata_b !== m_rb || bypass_a !== m_ba || bypass_b !== m_bb) begin
            fails++;
            $display("FAIL model_cmp t=%0t got a=%h b=%h ba=%b bb=%b expected a=%h b=%h ba=%b bb=%b",
                     $time, rdata_a, rdata_b, bypass_a, bypass_b, m_ra, m_rb, m_ba, m_bb);
         end
      end
   end

   task automatic set_in(input logic rst, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra, input logic [4:0] rb);
      @(negedge clk);
      areset = rst; we = w; waddr = wa; wdata = wd; rd_en = re; raddr_a = ra; raddr_b = rb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   initial begin
      tick();
      chk_en = 1'b1;
      lit("reset_rdata_a", rdata_a, 32'd0);
      lit("reset_bypass_b", {31'd0, bypass_b}, 32'd0);

      // Reset clears a previously written register
      set_in(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
      set_in(1, 0, 5'd0, 32'd0, 0, 0, 0);
      set_in(0, 0, 5'd0, 32'd0, 1, 5'd5, 5'd0);
      tick();
      lit("rst_r5_data", rdata_a, 32'd0);
      lit("rst_r5_byp", {31'd0, bypass_a}, 32'd0);

      // Write then read
      set_in(0, 1, 5'd7, 32'h12345678, 0, 0, 0);
      set_in(0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd0);
      tick();
      lit("wr_rd_data", rdata_a, 32'h12345678);
      lit("wr_rd_byp", {31'd0, bypass_a}, 32'd0);

      // Same-cycle bypass on both ports
      set_in(0, 1, 5'd9, 32'h1, 0, 0, 0);
      set_in(0, 1, 5'd9, 32'hA5A5A5A5, 1, 5'd9, 5'd9);
      tick();
      lit("byp_a_data", rdata_a, 32'hA5A5A5A5);
      lit("byp_b_data", rdata_b, 32'hA5A5A5A5);
      lit("byp_flags", {30'd0, bypass_a, bypass_b}, 32'd3);
      set_in(0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd9);
      tick();
      lit("post_byp_data", rdata_a, 32'hA5A5A5A5);
      lit("post_byp_flags", {30'd0, bypass_a, bypass_b}, 32'd0);

      // $zero stays zero, even against a same-cycle write
      set_in(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0);
      tick();
      lit("zero_same_a", rdata_a, 32'd0);
      lit("zero_same_flags", {30'd0, bypass_a, bypass_b}, 32'd0);
      set_in(0, 0, 5'd0, 32'd0, 1, 5'd0, 5'd0);
      tick();
      lit("zero_b", rdata_b, 32'd0);

      // Stall holds the capture while writes still commit
      set_in(0, 1, 5'd3, 32'h11, 0, 0, 0);
      set_in(0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0);
      tick();
      lit("stall_cap", rdata_a, 32'h11);
      for (int i = 0; i < 3; i++) begin
         set_in(0, 1, 5'd3, 32'h22, 0, 5'd3, 5'd3);
         tick();
         lit("stall_hold", rdata_a, 32'h11);
      end
      set_in(0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0);
      tick();
      lit("stall_release", rdata_a, 32'h22);

      // Reset wins over a simultaneous write and capture
      set_in(0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd7);
      set_in(1, 1, 5'd4, 32'h55, 1, 5'd4, 5'd4);
      tick();
      lit("rstpri_a", rdata_a, 32'd0);
      lit("rstpri_b", rdata_b, 32'd0);
      set_in(0, 0, 5'd0, 32'd0, 1, 5'd4, 5'd4);
      tick();
      lit("rstpri_r4", rdata_a, 32'd0);

      // Randomized traffic, biased towards address collisions
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] wa, ra, rb;
         wa = 5'($urandom_range(0, 31));
         ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         set_in(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, wa, $urandom,
                $urandom_range(0, 3) != 0, ra, rb);
      end
      set_in(0, 0, 5'd0, 32'd0, 0, 0, 0);
      tick();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- 32-entry x 32-bit MIPS general-purpose register file for the pipelined processor: one write port (WB stage), two read ports (ID stage).
- Read data is registered, so the block also forms the register-operand half of the ID/EX boundary.
- Same-cycle write-to-read bypass makes a WB-stage write visible to the instruction reading in that cycle.
- $0 reads as zero at all times.

Parameters:
- WIDTH, 32, data width of each register and of every data port.
- DEPTH_LOG2, 5, address width; the register count is 2**DEPTH_LOG2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- areset  input  1  reset, synchronous and active-high.
- we  input  1  write enable.
- waddr  input  5  write address.
- wdata  input  32  write data.
- rd_en  input  1  read enable; 0 = stall, hold both read outputs.
- raddr_a  input  5  read address, port A (rs).
- raddr_b  input  5  read address, port B (rt).
- rdata_a  output  32  registered read data, port A.
- rdata_b  output  32  registered read data, port B.
- bypass_a  output  1  registered flag: last rdata_a capture came from the bypass path.
- bypass_b  output  1  registered flag: last rdata_b capture came from the bypass path.

Behaviour:
- Reset, applied at a rising edge while areset=1:
  - all 32 registers cleared to 0.
  - rdata_a, rdata_b = 0; bypass_a, bypass_b = 0.
  - areset has priority over we and rd_en in the same cycle: no write, no capture.
- Write:
  - At the rising edge, if we=1, areset=0 and waddr!=0, then reg[waddr] <= wdata.
  - A write to address 0 is discarded; reg[0] stays 0.
- Read, one-cycle latency:
  - At the rising edge, if rd_en=1 and areset=0, rdata_a <= value(raddr_a) and rdata_b <= value(raddr_b).
- Value function value(x):
  - x==0: 0.
  - else if we=1 and waddr==x: wdata (bypass; the bypass flag for that port <= 1).
  - else: reg[x] (the bypass flag for that port <= 0).
- Ports A and B are independent. They may use the same address, including both bypassing the same write.
- Stall (rd_en=0): rdata_*/bypass_* hold their values. Writes still commit, so a write during a stall is not reflected until the next capture.
- A write and a capture of the same register in one edge: the capture returns the new wdata, never the stale value.
- No internal FSM beyond storage. The read pipeline has two states per port: HOLD (rd_en=0) and CAPTURE (rd_en=1).
- X on waddr while we=0 must not corrupt state.
- All arithmetic is address compare only; no wrap-around concerns. Addresses are exactly 5 bits.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert areset 1 cycle, then read r5 on A -> rdata_a=0, bypass_a=0 after one edge.
- Write then read: cycle 0 write r7=0x12345678. Cycle 1 rd_en=1 with raddr_a=7 -> after edge, rdata_a=0x12345678, bypass_a=0.
- Same-cycle bypass: we=1, waddr=9, wdata=0xA5A5A5A5, rd_en=1, raddr_a=raddr_b=9, with r9 previously 0x1 -> rdata_a=rdata_b=0xA5A5A5A5, bypass_a=bypass_b=1. The next capture of r9 gives 0xA5A5A5A5 with bypass=0.
- $zero: write r0=0xFFFFFFFF, then read r0 on both ports, including same-cycle with the write -> rdata=0, bypass=0.
- Stall hold: capture r3=0x11 on A, then rd_en=0 for 3 cycles while writing r3=0x22 -> rdata_a stays 0x11. rd_en=1 -> rdata_a=0x22.
- Reset priority: areset=1 together with we=1 (r4=0x55) and rd_en=1 -> r4 reads 0 afterwards and outputs are 0.
